// File: rtl/board_run_ctrl.sv
// Board run controller: debounced push-buttons drive the CPU through IDLE/BOOT/RUN/HALT/STEP/BURST.
// Optional breakpoint halt is compiled in with `define BOARD_CTRL_BREAK_EN.
module board_run_ctrl #(
  parameter int DB_W         = 20,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int BURST_LEN    = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             inc,
  input  logic             burst,
`ifdef BOARD_CTRL_BREAK_EN
  input  logic [15:0]      pc,
  input  logic [15:0]      bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit,
`endif
  output logic             enable_control,
  output logic             start_control,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [15:0]     BURST_LD = 16'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_RUN, S_HALT, S_STEP, S_BURST
  } state_t;

  // Button order doubles as event priority: bit 0 wins.
  logic [3:0] btn_raw;
  logic [3:0] btn_ev;
  assign btn_raw = {inc, burst, start, stop};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic            s1_q, s2_q, lvl_q, lvl_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            ev;

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      ev    = 1'b0;
      if (s2_q != lvl_q) begin
        if (cnt_q == DB_LAST) begin
          lvl_d = s2_q;
          ev    = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn_raw[gi];
        s2_q  <= s1_q;
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    assign btn_ev[gi] = ev;
  end

  logic ev_stop, ev_start, ev_burst, ev_inc;
  assign ev_stop  = btn_ev[0];
  assign ev_start = btn_ev[1] & ~btn_ev[0];
  assign ev_burst = btn_ev[2] & ~|btn_ev[1:0];
  assign ev_inc   = btn_ev[3] & ~|btn_ev[2:0];

  state_t           state_q, state_d;
  logic [15:0]      burst_left_q, burst_left_d;
  logic             pend_stop_q, pend_stop_d;
  logic             enable_q, enable_d;
  logic             start_ctl_q, start_ctl_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bp_hit_q, bp_hit_d;

  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;
    pend_stop_d  = 1'b0;
    bp_hit_d     = 1'b0;
    unique case (state_q)
      S_IDLE:  if (ev_start) state_d = S_BOOT;
      S_BOOT: begin
        // A stop caught while booting is replayed in the first RUN cycle.
        pend_stop_d = ev_stop;
        state_d     = S_RUN;
      end
      S_RUN:   if (ev_stop || pend_stop_q) state_d = S_HALT;
      S_HALT: begin
        if (ev_start) begin
          state_d = S_RUN;
        end else if (ev_burst) begin
          state_d      = S_BURST;
          burst_left_d = BURST_LD;
        end else if (ev_inc) begin
          state_d = S_STEP;
        end
      end
      S_STEP:  state_d = S_HALT;
      S_BURST: begin
        burst_left_d = burst_left_q - 1'b1;
        if (ev_stop || burst_left_q == 16'd1) state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BOARD_CTRL_BREAK_EN
    if ((state_q == S_RUN || state_q == S_BURST) && enable_q && bp_valid && pc == bp_addr) begin
      state_d  = S_HALT;
      bp_hit_d = 1'b1;
    end
`endif
  end

  always_comb begin
    enable_d    = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_BURST);
    start_ctl_d = (state_d == S_BOOT);
    running_d   = enable_d || (state_d == S_BOOT);
    halted_d    = (state_d == S_HALT);
    count_d     = enable_q ? count_q + 1'b1 : count_q;
    if (state_d == S_BOOT) count_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      burst_left_q <= '0;
      pend_stop_q  <= 1'b0;
      enable_q     <= 1'b0;
      start_ctl_q  <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= '0;
      bp_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      pend_stop_q  <= pend_stop_d;
      enable_q     <= enable_d;
      start_ctl_q  <= start_ctl_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  assign enable_control = enable_q;
  assign start_control  = start_ctl_q;
  assign running        = running_q;
  assign halted         = halted_q;
  assign step_count     = count_q;
`ifdef BOARD_CTRL_BREAK_EN
  assign bp_hit         = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = bp_hit_q;
`endif

endmodule

// File: tb/tb_board_run_ctrl.sv
// Self-checking bench for board_run_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a behavioural model of the button rules and run modes.
module tb_board_run_ctrl;
  localparam int D  = 4;
  localparam int BL = 5;
  localparam int CW = 4;

  localparam int M_IDLE = 0, M_BOOT = 1, M_RUN = 2, M_HALT = 3, M_STEP = 4, M_BURST = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, inc = 1'b0, burst = 1'b0;
  logic enable_control, start_control, running, halted;
  logic [CW-1:0] step_count;
`ifdef BOARD_CTRL_BREAK_EN
  logic [15:0] pc = 16'd0, bp_addr = 16'd0;
  logic bp_valid = 1'b0;
  logic bp_hit;
`endif

  board_run_ctrl #(.DB_W(8), .DEBOUNCE_CNT(D), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .start(start), .stop(stop), .inc(inc), .burst(burst),
`ifdef BOARD_CTRL_BREAK_EN
    .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
    .enable_control(enable_control), .start_control(start_control),
    .running(running), .halted(halted), .step_count(step_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: each button accepts a new level once its synchronised input
  // (raw delayed two clocks) has disagreed with the accepted level for D consecutive clocks.
  bit hist[4][D+2];
  bit m_lvl[4];
  int m_mode, m_cnt, m_left;
  bit m_pend, m_bphit;

  function automatic bit mode_en(input int md);
    return md == M_RUN || md == M_STEP || md == M_BURST;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_lvl[b] = 1'b0;
      for (int j = 0; j < D + 2; j++) hist[b][j] = 1'b0;
    end
    m_mode = M_IDLE; m_cnt = 0; m_left = 0; m_pend = 1'b0; m_bphit = 1'b0;
  endtask

  task automatic model_edge();
    bit raw[4];
    int ev;
    bit old_en;
    int old_mode;
    if (!reset) return;
    raw = '{stop, start, burst, inc};
    ev = -1;
    for (int b = 0; b < 4; b++) begin
      bit all_diff;
      for (int j = D + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = raw[b];
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[b][j] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[b] = ~m_lvl[b];
        if (m_lvl[b] && ev < 0) ev = b;
      end
    end
    old_en   = mode_en(m_mode);
    old_mode = m_mode;
    if (old_en) m_cnt = (m_cnt + 1) % (1 << CW);
    m_bphit = 1'b0;
    case (m_mode)
      M_IDLE:  if (ev == 1) begin m_mode = M_BOOT; m_cnt = 0; end
      M_BOOT:  begin m_pend = (ev == 0); m_mode = M_RUN; end
      M_RUN:   begin if (ev == 0 || m_pend) m_mode = M_HALT; m_pend = 1'b0; end
      M_HALT:  begin
        if (ev == 1) m_mode = M_RUN;
        else if (ev == 2) begin m_mode = M_BURST; m_left = BL; end
        else if (ev == 3) m_mode = M_STEP;
      end
      M_STEP:  m_mode = M_HALT;
      default: begin
        if (ev == 0 || m_left == 1) m_mode = M_HALT;
        m_left--;
      end
    endcase
`ifdef BOARD_CTRL_BREAK_EN
    if ((old_mode == M_RUN || old_mode == M_BURST) && old_en && bp_valid && pc == bp_addr) begin
      m_mode = M_HALT; m_bphit = 1'b1;
    end
`else
    if (old_mode < 0) m_bphit = 1'b1;
`endif
  endtask

  task automatic check_all();
    check_val("enable_control", enable_control, mode_en(m_mode));
    check_val("start_control", start_control, m_mode == M_BOOT);
    check_val("running", running, m_mode != M_IDLE && m_mode != M_HALT);
    check_val("halted", halted, m_mode == M_HALT);
    check_val("step_count", step_count, m_cnt);
`ifdef BOARD_CTRL_BREAK_EN
    check_val("bp_hit", bp_hit, m_bphit);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: stop = v;
      1: start = v;
      2: burst = v;
      default: inc = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    string names[4] = '{"stop", "start", "burst", "inc"};
    set_btn(b, 1'b1);
    idle(hold);
    set_btn(b, 1'b0);
    $display("press %s hold=%0d -> mode=%0d count=%0d", names[b], hold, m_mode, m_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    $display("reset asserted");
    idle(2);
    reset = 1'b1;
  endtask

  int base, lat, width, hits;

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();
    idle(4);
    check_val("reset_idle_running", running, 1'b0);

    press(3, D + 4); press(2, D + 4); idle(8);
    check_val("idle_ignores_inc_burst", running, 1'b0);

    start = 1'b1; lat = 0; width = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (start_control && lat == 0) lat = i;
      width += int'(start_control);
    end
    start = 1'b0;
    check_val("start_latency", lat, D + 2);
    check_val("start_width", width, 1);
    $display("start press: latency=%0d width=%0d", lat, width);

    press(0, D - 1); idle(10);
    check_val("glitch_no_halt", halted, 1'b0);

    press(0, D + 2); idle(10);
    check_val("stop_halts", halted, 1'b1);
    base = m_cnt;
    for (int k = 0; k < 3; k++) begin press(3, D + 2); idle(8); end
    check_val("inc_x3", step_count, (base + 3) % 16);

    base = m_cnt;
    press(2, D + 2); idle(12);
    check_val("burst_full", step_count, (base + BL) % 16);
    check_val("burst_ends_halted", halted, 1'b1);

    base = m_cnt;
    burst = 1'b1; idle(2); stop = 1'b1; idle(D + 8);
    burst = 1'b0; stop = 1'b0; idle(10);
    $display("burst then stop after 2 -> count=%0d", m_cnt);
    check_val("burst_stop2", step_count, (base + 2) % 16);

    press(1, D + 2); idle(25);
    check_val("run_wrap_running", running, 1'b1);
    stop = 1'b1; inc = 1'b1; idle(D + 3); stop = 1'b0; inc = 1'b0;
    base = m_cnt; idle(10);
    $display("stop+inc together -> mode=%0d", m_mode);
    check_val("stop_inc_halt", halted, 1'b1);
    check_val("stop_inc_no_step", step_count, base);

    press(1, D + 2); press(2, D + 2); idle(3);
    do_reset(); idle(5);
    check_val("reset_mid_run_idle", running, 1'b0);

    start = 1'b1; idle(1); stop = 1'b1; idle(D + 6); start = 1'b0; stop = 1'b0; idle(10);
    $display("stop during boot -> mode=%0d count=%0d", m_mode, m_cnt);
    check_val("boot_stop_count", step_count, 1);
    check_val("boot_stop_halted", halted, 1'b1);

    for (int t = 0; t < 200; t++) begin
      press($urandom_range(0, 3), $urandom_range(1, D + 4));
      idle($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) do_reset();
    end

`ifdef BOARD_CTRL_BREAK_EN
    do_reset(); idle(2);
    bp_addr = 16'h0010; bp_valid = 1'b1; pc = 16'h0000;
    press(1, D + 2);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hits += int'(bp_hit);
      if (!halted) pc = pc + 16'd1;
    end
    $display("breakpoint run -> mode=%0d pc=%0h hits=%0d", m_mode, pc, hits);
    check_val("bp_halted", halted, 1'b1);
    check_val("bp_hit_pulses", hits, 1);
    base = m_cnt;
    press(3, D + 2); idle(8);
    check_val("bp_step_off", step_count, (base + 1) % 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
